// File: rtl/mem_line_bridge.sv
// Line-to-word memory bridge: serves a 256-bit cache line request as eight
// sequential 32-bit req/ack transactions on a narrow memory port.
module mem_line_bridge #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              write_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LINE_W-1:0] data_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o,
   output logic              busy_o,
   output logic              nmem_req_o,
   output logic              nmem_we_o,
   output logic [ADDR_W-1:0] nmem_addr_o,
   output logic [WORD_W-1:0] nmem_wdata_o,
   input  logic              nmem_ack_i,
   input  logic [WORD_W-1:0] nmem_rdata_i
);

   localparam int BEATS  = LINE_W / WORD_W;
   localparam int BYTE_W = $clog2(WORD_W / 8);
   localparam int OFF_W  = BYTE_W + 3;
   localparam int BASE_W = ADDR_W - OFF_W;

   if (LINE_W != 8 * WORD_W) begin : g_ratio_chk
      $error("mem_line_bridge: LINE_W/WORD_W must be exactly 8");
   end

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_RESP, S_GAP} state_t;

   state_t                    state_q;
   logic [2:0]                beat_q;
   logic [2:0]                beat_d;
   logic [BASE_W-1:0]         base_q;
   logic                      we_q;
   logic [LINE_W-1:0]         line_q;
   logic [LINE_W-WORD_W-1:0]  asm_q;
   logic                      unused_addr_bits;

   assign unused_addr_bits = ^addr_i[OFF_W-1:0];

   always_comb begin
      beat_d = beat_q + 3'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         beat_q       <= '0;
         base_q       <= '0;
         we_q         <= 1'b0;
         line_q       <= '0;
         asm_q        <= '0;
         ack_o        <= 1'b0;
         data_o       <= '0;
         busy_o       <= 1'b0;
         nmem_req_o   <= 1'b0;
         nmem_we_o    <= 1'b0;
         nmem_addr_o  <= '0;
         nmem_wdata_o <= '0;
      end else begin
         ack_o <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (enable_i) begin
                  state_q      <= S_XFER;
                  beat_q       <= '0;
                  base_q       <= addr_i[ADDR_W-1:OFF_W];
                  we_q         <= write_i;
                  line_q       <= data_i;
                  busy_o       <= 1'b1;
                  nmem_req_o   <= 1'b1;
                  nmem_we_o    <= write_i;
                  nmem_addr_o  <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  nmem_wdata_o <= data_i[WORD_W-1:0];
               end
            end
            S_XFER: begin
               if (nmem_ack_i) begin
                  if (beat_q == 3'(BEATS - 1)) begin
                     // Last word goes straight into data_o; earlier words sit in asm_q.
                     state_q    <= S_RESP;
                     ack_o      <= 1'b1;
                     nmem_req_o <= 1'b0;
                     nmem_we_o  <= 1'b0;
                     if (!we_q) begin
                        data_o <= {nmem_rdata_i, asm_q};
                     end
                  end else begin
                     if (!we_q) begin
                        asm_q[int'(beat_q)*WORD_W +: WORD_W] <= nmem_rdata_i;
                     end
                     beat_q       <= beat_d;
                     nmem_addr_o  <= {base_q, beat_d, {BYTE_W{1'b0}}};
                     nmem_wdata_o <= line_q[int'(beat_d)*WORD_W +: WORD_W];
                  end
               end
            end
            S_RESP: begin
               state_q <= S_GAP;
            end
            S_GAP: begin
               state_q <= S_IDLE;
               busy_o  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
